// File: rtl/aes_iter_core.sv
// aes_iter_core: iterative FIPS-197 AES-128 encrypt/decrypt, UNROLL rounds per clock (R = 10/UNROLL stages).
// Latency: encrypt R edges after accept; decrypt 2R (KEYGEN walks the schedule to round key 10 first).
// Backpressure: one block in flight; in_ready only in IDLE, result held in DONE until out_ready.
// Ports: clk, rst (sync, active-high); in_valid/in_ready with mode (1=decrypt), key, data_in;
//        out_valid/out_ready with data_out (0 while out_valid=0); busy = FSM not IDLE.
// Optional AES_KEYCACHE_EN: CACHE_DEPTH {key, round key 10} pairs let a repeated decrypt key skip KEYGEN.
module aes_iter_core #(
  parameter int UNROLL      = 1,
  parameter int CACHE_DEPTH = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         mode,
  input  logic [127:0] key,
  input  logic [127:0] data_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] data_out,
  output logic         busy
);
  localparam int R = 10 / UNROLL;
  localparam logic [3:0] CNT_LAST = 4'(R - 1);

  // Byte 0 of a block is the most significant byte, column-major state order.
  typedef logic [0:15][7:0] blk_t;
  typedef enum logic [1:0] {IDLE, KEYGEN, ROUND, DONE} state_t;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (0 maps to 0); avoids storing S-box tables.
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] p;
    r = 8'h01;
    p = a;
    for (int i = 0; i < 7; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] i;
    i = ginv(a);
    return i ^ {i[6:0], i[7]} ^ {i[5:0], i[7:6]} ^ {i[4:0], i[7:5]} ^ {i[3:0], i[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    return ginv({a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05);
  endfunction

  function automatic logic [7:0] rcon(input logic [7:0] r);
    case (r)
      8'd1:    return 8'h01;
      8'd2:    return 8'h02;
      8'd3:    return 8'h04;
      8'd4:    return 8'h08;
      8'd5:    return 8'h10;
      8'd6:    return 8'h20;
      8'd7:    return 8'h40;
      8'd8:    return 8'h80;
      8'd9:    return 8'h1b;
      8'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [31:0] subrot(input logic [31:0] w, input logic [7:0] rc);
    return {sbox(w[23:16]) ^ rc, sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
  endfunction

  function automatic logic [127:0] key_next(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    {w0, w1, w2, w3} = k;
    w0 = w0 ^ subrot(w3, rc);
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // Undo key_next: recover the previous round key from the current one.
  function automatic logic [127:0] key_prev(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    {w0, w1, w2, w3} = k;
    w3 = w3 ^ w2;
    w2 = w2 ^ w1;
    w1 = w1 ^ w0;
    w0 = w0 ^ subrot(w3, rc);
    return {w0, w1, w2, w3};
  endfunction

  function automatic logic [127:0] enc_round(input logic [127:0] s, input logic [127:0] k, input logic last);
    blk_t a, b;
    logic [7:0] a0, a1, a2, a3;
    a = s;
    for (int i = 0; i < 16; i++) a[i] = sbox(a[i]);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) b[4*c+r] = a[4*((c+r)%4)+r];
    if (!last) begin
      for (int c = 0; c < 4; c++) begin
        a0 = b[4*c]; a1 = b[4*c+1]; a2 = b[4*c+2]; a3 = b[4*c+3];
        b[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
        b[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
        b[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
        b[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
      end
    end
    return b ^ k;
  endfunction

  function automatic logic [127:0] dec_round(input logic [127:0] s, input logic [127:0] k, input logic last);
    blk_t a, b;
    logic [7:0] a0, a1, a2, a3;
    a = s;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) b[4*c+r] = inv_sbox(a[4*((c-r+4)%4)+r]);
    b = b ^ k;
    if (!last) begin
      for (int c = 0; c < 4; c++) begin
        a0 = b[4*c]; a1 = b[4*c+1]; a2 = b[4*c+2]; a3 = b[4*c+3];
        b[4*c]   = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
        b[4*c+1] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
        b[4*c+2] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
        b[4*c+3] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
      end
    end
    return b;
  endfunction

  state_t       state;
  logic [3:0]   cnt;
  logic         mode_r;
  logic [127:0] key_r, st, rk;
  logic [127:0] st_ch [0:UNROLL];
  logic [127:0] rk_ch [0:UNROLL];
  logic [7:0]   rnd;
  logic         hit;
  logic [127:0] hit_rk;

`ifdef AES_KEYCACHE_EN
  localparam int PW = (CACHE_DEPTH > 1) ? $clog2(CACHE_DEPTH) : 1;
  logic [127:0] c_key [CACHE_DEPTH];
  logic [127:0] c_rk  [CACHE_DEPTH];
  logic         c_vld [CACHE_DEPTH];
  logic [PW-1:0] c_ptr;

  always_comb begin
    hit    = 1'b0;
    hit_rk = '0;
    for (int i = 0; i < CACHE_DEPTH; i++) begin
      if (c_vld[i] && c_key[i] == key) begin
        hit    = 1'b1;
        hit_rk = c_rk[i];
      end
    end
  end
`else
  assign hit    = 1'b0;
  assign hit_rk = '0;
`endif

  // Unrolled round chain. KEYGEN reuses the forward key path; the state path is ignored there.
  always_comb begin
    rnd      = 8'd0;
    rk_ch[0] = rk;
    st_ch[0] = st;
    // The block was whitened with the cipher key at accept; decrypt needs round key 10 instead.
    if (mode_r && state == ROUND && cnt == 4'd0) st_ch[0] = st ^ key_r ^ rk;
    for (int u = 0; u < UNROLL; u++) begin
      rnd = 8'(int'(cnt) * UNROLL + u + 1);
      if (mode_r && state == ROUND) begin
        rk_ch[u+1] = key_prev(rk_ch[u], rcon(8'(8'd11 - rnd)));
        st_ch[u+1] = dec_round(st_ch[u], rk_ch[u+1], rnd == 8'd10);
      end else begin
        rk_ch[u+1] = key_next(rk_ch[u], rcon(rnd));
        st_ch[u+1] = enc_round(st_ch[u], rk_ch[u+1], rnd == 8'd10);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      data_out  <= '0;
      cnt       <= '0;
`ifdef AES_KEYCACHE_EN
      for (int i = 0; i < CACHE_DEPTH; i++) c_vld[i] <= 1'b0;
      c_ptr <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            key_r    <= key;
            mode_r   <= mode;
            st       <= data_in ^ key;
            rk       <= (mode && hit) ? hit_rk : key;
            cnt      <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= (mode && !hit) ? KEYGEN : ROUND;
          end
        end
        KEYGEN: begin
          rk <= rk_ch[UNROLL];
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            state <= ROUND;
`ifdef AES_KEYCACHE_EN
            c_key[c_ptr] <= key_r;
            c_rk[c_ptr]  <= rk_ch[UNROLL];
            c_vld[c_ptr] <= 1'b1;
            c_ptr        <= (c_ptr == PW'(CACHE_DEPTH - 1)) ? '0 : c_ptr + 1'b1;
`endif
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        ROUND: begin
          st <= st_ch[UNROLL];
          rk <= rk_ch[UNROLL];
          if (cnt == CNT_LAST) begin
            cnt       <= '0;
            state     <= DONE;
            out_valid <= 1'b1;
            data_out  <= st_ch[UNROLL];
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            data_out  <= '0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_iter_core.sv
// tb_aes_iter_core: drives UNROLL=1 and UNROLL=5 cores with the same request stream.
// Expected blocks and latencies are queued per core when a request is driven, checked on output.
module tb_aes_iter_core;
`ifdef AES_KEYCACHE_EN
  localparam bit CACHE_ON = 1'b1;
`else
  localparam bit CACHE_ON = 1'b0;
`endif
  localparam int CD = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic mode = 1'b0;
  logic [127:0] key = '0;
  logic [127:0] data_in = '0;
  logic out_ready = 1'b1;
  logic [1:0] rdy, ov, bsy;
  logic [1:0][127:0] dout;

  always #5 clk = ~clk;

  aes_iter_core #(.UNROLL(1), .CACHE_DEPTH(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[0]), .mode(mode), .key(key),
    .data_in(data_in), .out_valid(ov[0]), .out_ready(out_ready), .data_out(dout[0]), .busy(bsy[0]));

  aes_iter_core #(.UNROLL(5), .CACHE_DEPTH(1)) u5 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[1]), .mode(mode), .key(key),
    .data_in(data_in), .out_valid(ov[1]), .out_ready(out_ready), .data_out(dout[1]), .busy(bsy[1]));

  typedef struct { logic [127:0] data; int lat; int acc; } exp_t;
  typedef struct packed { logic m; logic [127:0] k; logic [127:0] d; logic [127:0] e; } vec_t;

  exp_t sb0[$];
  exp_t sb1[$];
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  logic [127:0] mdl_key [4];
  bit mdl_v [4];
  int mdl_ptr = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  function automatic bit model_hit(input logic [127:0] k);
    for (int i = 0; i < CD; i++) if (mdl_v[i] && mdl_key[i] == k) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 4; i++) mdl_v[i] = 1'b0;
    mdl_ptr = 0;
  endtask

  task automatic push(input logic [127:0] e, input int mult, input int acc);
    sb0.push_back('{data: e, lat: 10 * mult, acc: acc});
    sb1.push_back('{data: e, lat: 2 * mult, acc: acc});
  endtask

  task automatic scramble();
    mode = 1'($urandom);
    key = {$urandom, $urandom, $urandom, $urandom};
    data_in = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic send(input logic m, input logic [127:0] k, input logic [127:0] d, input logic [127:0] e);
    int w;
    bit hit;
    w = 0;
    @(negedge clk);
    while (rdy != 2'b11 && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk("send_wait in_ready", 128'(rdy), 128'(2'b11));
    in_valid = 1'b1;
    mode = m;
    key = k;
    data_in = d;
    hit = CACHE_ON && model_hit(k);
    push(e, (m && !hit) ? 2 : 1, cyc + 1);
    if (m && !hit) begin
      mdl_key[mdl_ptr] = k;
      mdl_v[mdl_ptr] = 1'b1;
      mdl_ptr = (mdl_ptr + 1) % CD;
    end
    @(negedge clk);
    in_valid = 1'b0;
    scramble();
    chk("accept busy", 128'(bsy), 128'(2'b11));
  endtask

  task automatic drain();
    int w;
    w = 0;
    while ((sb0.size() != 0 || sb1.size() != 0) && w < 1000) begin
      @(negedge clk);
      w++;
    end
    chk("drain pending", 128'(sb0.size() + sb1.size()), 128'(0));
  endtask

  // Output monitor: latency on out_valid rise, stability while held, data at handshake, zero when idle.
  initial begin
    logic [1:0] prev_ov;
    logic [127:0] held [2];
    exp_t e;
    prev_ov = 2'b00;
    forever begin
      @(negedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
        if (ov[d]) begin
          if (!prev_ov[d]) begin
            held[d] = dout[d];
            if ((d == 0 ? sb0.size() : sb1.size()) == 0) begin
              chk($sformatf("u%0d unexpected out_valid", d), 128'(1), 128'(0));
            end else begin
              e = (d == 0) ? sb0[0] : sb1[0];
              chk($sformatf("u%0d latency", d), 128'(cyc - e.acc), 128'(e.lat));
            end
          end else begin
            chk($sformatf("u%0d data_out stable", d), dout[d], held[d]);
          end
          if (out_ready && (d == 0 ? sb0.size() : sb1.size()) != 0) begin
            e = (d == 0) ? sb0.pop_front() : sb1.pop_front();
            chk($sformatf("u%0d data_out", d), dout[d], e.data);
          end
        end else begin
          chk($sformatf("u%0d data_out idle zero", d), dout[d], 128'(0));
        end
        prev_ov[d] = ov[d];
      end
    end
  end

  initial begin
    vec_t vt [14];
    logic [127:0] k1, p1, c1, k2, pb, cb;
    int w;
    k1 = 128'h000102030405060708090a0b0c0d0e0f;
    p1 = 128'h00112233445566778899aabbccddeeff;
    c1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    k2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    pb = 128'h3243f6a8885a308d313198a2e0370734;
    cb = 128'h3925841d02dc09fbdc118597196a0b32;
    vt[0]  = {1'b0, k1, p1, c1};
    vt[1]  = {1'b1, k1, c1, p1};
    vt[2]  = {1'b1, k1, c1, p1};
    vt[3]  = {1'b0, k2, pb, cb};
    vt[4]  = {1'b1, k2, cb, pb};
    vt[5]  = {1'b0, k2, 128'h6bc1bee22e409f96e93d7e117393172a, 128'h3ad77bb40d7a3660a89ecaf32466ef97};
    vt[6]  = {1'b0, k2, 128'hae2d8a571e03ac9c9eb76fac45af8e51, 128'hf5d3d58503b9699de785895a96fdbaaf};
    vt[7]  = {1'b0, k2, 128'h30c81c46a35ce411e5fbc1191a0a52ef, 128'h43b1cd7f598ece23881b00e3ed030688};
    vt[8]  = {1'b0, k2, 128'hf69f2445df4f9b17ad2b417be66c3710, 128'h7b0c785e27e8ad3f8223207104725dd4};
    vt[9]  = {1'b1, k2, 128'h3ad77bb40d7a3660a89ecaf32466ef97, 128'h6bc1bee22e409f96e93d7e117393172a};
    vt[10] = {1'b1, k2, 128'h7b0c785e27e8ad3f8223207104725dd4, 128'hf69f2445df4f9b17ad2b417be66c3710};
    vt[11] = {1'b0, 128'h0, 128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e};
    vt[12] = {1'b1, 128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e, 128'h0};
    vt[13] = {1'b1, k1, c1, p1};
    model_clear();

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset in_ready", 128'(rdy), 128'(2'b11));
    chk("reset out_valid", 128'(ov), 128'(2'b00));
    chk("reset busy", 128'(bsy), 128'(2'b00));
    chk("reset data_out", dout[0] | dout[1], 128'(0));
    rst = 1'b0;

    for (int i = 0; i < 14; i++) send(vt[i].m, vt[i].k, vt[i].d, vt[i].e);
    drain();

    // Backpressure: result held in DONE, pending request accepted only after the handshake.
    @(negedge clk);
    out_ready = 1'b0;
    send(1'b0, k1, p1, c1);
    w = 0;
    while (!ov[0] && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk("bp wait out_valid", 128'(ov[0]), 128'(1));
    in_valid = 1'b1;
    mode = 1'b0;
    key = k2;
    data_in = vt[6].d;
    repeat (7) begin
      chk("bp in_ready", 128'(rdy), 128'(2'b00));
      chk("bp busy", 128'(bsy), 128'(2'b11));
      @(negedge clk);
    end
    out_ready = 1'b1;
    push(vt[6].e, 1, cyc + 2);
    @(negedge clk);
    chk("post-handshake in_ready", 128'(rdy), 128'(2'b11));
    chk("post-handshake busy", 128'(bsy), 128'(2'b00));
    @(negedge clk);
    in_valid = 1'b0;
    scramble();
    chk("pending accepted busy", 128'(bsy), 128'(2'b11));
    drain();

    // Reset during the 4th ROUND cycle of the UNROLL=1 core.
    send(1'b0, k1, p1, c1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrun reset in_ready", 128'(rdy[0]), 128'(1));
    chk("midrun reset out_valid", 128'(ov[0]), 128'(0));
    chk("midrun reset busy", 128'(bsy[0]), 128'(0));
    chk("midrun reset data_out", dout[0], 128'(0));
    sb0.delete();
    model_clear();
    send(1'b0, k1, p1, c1);
    send(1'b1, k1, c1, p1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_iter_core.md
AES_ITER_CORE -- requirements
Module: aes_iter_core

Interface
REQ-001 The block SHALL have parameter UNROLL, default 1, giving rounds per clock; legal values are 1, 2, 5 and 10.
REQ-002 The block SHALL have parameter CACHE_DEPTH, default 1, giving the number of cached decrypt keys when AES_KEYCACHE_EN is defined; legal values are 1 to 4.
REQ-003 The block SHALL have the following ports:
- clk  in  1  sole clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  a request is present.
- in_ready  out  1  the core can accept a request.
- mode  in  1  0 = encrypt, 1 = decrypt; sampled at accept.
- key  in  128  AES-128 cipher key; byte 0 = key[127:120].
- data_in  in  128  plaintext or ciphertext block; byte 0 = data_in[127:120].
- out_valid  out  1  data_out holds a result.
- out_ready  in  1  the consumer takes the result.
- data_out  out  128  result block.
- busy  out  1  the FSM is not in IDLE.

Function
REQ-004 The core SHALL implement FIPS-197 AES-128 encryption and decryption (10 rounds, no MixColumns in the final round) iteratively, with R = 10/UNROLL round stages per block.
REQ-005 The FSM SHALL have states IDLE, KEYGEN, ROUND and DONE; in_ready SHALL be 1 only in IDLE.
REQ-006 An accept (in_valid and in_ready at an edge) SHALL latch key, mode and data_in XOR key, then move to ROUND if mode=0 or KEYGEN if mode=1.
REQ-007 KEYGEN SHALL run the forward key schedule for R cycles to reach round key 10, then enter ROUND.
REQ-008 In ROUND, each cycle SHALL apply UNROLL rounds, deriving round keys on the fly: forward schedule for encrypt, inverse schedule for decrypt.
REQ-009 After the R-th ROUND cycle the FSM SHALL enter DONE with out_valid=1.
REQ-010 Encrypt latency SHALL be accept edge plus R edges; decrypt latency SHALL be accept edge plus 2R edges.
REQ-011 In DONE, data_out and out_valid SHALL stay stable until out_ready=1.
REQ-012 When out_valid and out_ready are both 1 at an edge, the FSM SHALL return to IDLE; no new request is accepted in that same cycle.
REQ-013 in_valid and changes to mode, key or data_in outside the accept edge SHALL have no effect.
REQ-014 data_out SHALL be 0 whenever out_valid=0.

Reset
REQ-015 With rst=1 at an edge, the FSM SHALL go to IDLE, with in_ready=1, out_valid=0, busy=0 and data_out=0.
REQ-016 Reset SHALL take effect mid-operation in any state, discarding the block in flight with no result produced.
REQ-017 Reset SHALL clear all key-cache entries to invalid.
REQ-018 rst SHALL override a simultaneous accept or output handshake.

Configuration
REQ-019 With macro AES_KEYCACHE_EN defined, the core SHALL store up to CACHE_DEPTH pairs of {cipher key, round key 10}, replaced round-robin after each KEYGEN.
REQ-020 With AES_KEYCACHE_EN defined, a decrypt accept whose key hits a valid cache entry SHALL skip KEYGEN, giving latency R; encrypt SHALL be unaffected.
REQ-021 Without AES_KEYCACHE_EN, no cache storage SHALL exist and every decrypt SHALL pass through KEYGEN.

Verification
REQ-022 UNROLL=1; encrypt key 000102030405060708090a0b0c0d0e0f, data 00112233445566778899aabbccddeeff -> data_out 69c4e0d86a7b0430d8cdb78070b4c55a, out_valid rising 10 edges after accept.
REQ-023 UNROLL=1; decrypt the same key with data 69c4e0d86a7b0430d8cdb78070b4c55a -> data_out 00112233445566778899aabbccddeeff after 20 edges; with AES_KEYCACHE_EN, a repeat decrypt with that key completes after 10 edges.
REQ-024 UNROLL=5; encrypt key 2b7e151628aed2a6abf7158809cf4f3c, data 3243f6a8885a308d313198a2e0370734 -> data_out 3925841d02dc09fbdc118597196a0b32 after 2 edges.
REQ-025 Backpressure: hold out_ready=0 for 7 cycles in DONE -> data_out stays stable, in_ready=0, and a pending in_valid is not accepted until the cycle after the output handshake.
REQ-026 Reset test: assert rst during the 4th ROUND cycle -> the next cycle shows in_ready=1, out_valid=0, busy=0; a following encrypt gives a correct result, and with AES_KEYCACHE_EN the next decrypt takes 2R edges (cache cleared).
